lcd_ctrl_seq: RTL and testbench

- Control sequencer for the LCD image controller.
- Owns the single shared ADDR bus and the IROM_EN / IRB_RW strobes, and runs the busy/done handshake with the command source.
- Sequences three phases: the 64-byte IROM load into the image datapath, command dispatch to the datapath, and the 64-byte IRB writeback.
- Moves no pixel data itself. It gives the datapath capture and drive strobes with addresses.

---
 rtl/lcd_ctrl_seq_if.sv | 33 +++
 rtl/lcd_ctrl_seq.sv | 163 ++++++++++++++++
 tb/tb_lcd_ctrl_seq.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/lcd_ctrl_seq_if.sv
// Command/strobe bundle between the LCD sequencer (master) and the
// command source, IROM/IRB memories and image datapath (slave).
interface lcd_ctrl_seq_if #(
  parameter int ADDR_W = 6
);
  logic [2:0]        cmd;
  logic              cmd_valid;
  logic              busy;
  logic              done;
  logic              IROM_EN;
  logic              IRB_RW;
  logic [ADDR_W-1:0] ADDR;
  logic              img_we;
  logic [ADDR_W-1:0] img_addr;
  logic              op_go;
  logic [2:0]        op_cmd;
  logic              op_ack;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic              err;

  modport master (
    input  cmd, cmd_valid, op_ack,
    output busy, done, IROM_EN, IRB_RW, ADDR, img_we, img_addr,
           op_go, op_cmd, wb_en, wb_addr, err
  );

  modport slave (
    output cmd, cmd_valid, op_ack,
    input  busy, done, IROM_EN, IRB_RW, ADDR, img_we, img_addr,
           op_go, op_cmd, wb_en, wb_addr, err
  );
endinterface

// File: rtl/lcd_ctrl_seq.sv
// LCD image controller sequencer: IROM load, op dispatch, IRB writeback.
// Define LCD_SEQ_OP_TIMEOUT_EN to abort ops that never see op_ack.
//   state     | meaning
//   LOAD_RD   | IROM read, ADDR 0..N_WORDS-1 (first cycle after reset is setup)
//   LOAD_TAIL | capture of the last IROM byte
//   IDLE      | waiting for a command, busy=0
//   OP        | datapath operation in flight, waiting for op_ack
//   WRITE     | IRB write, ADDR 0..N_WORDS-1
//   FIN       | done pulse
module lcd_ctrl_seq #(
  parameter int ADDR_W  = 6,
  parameter int N_WORDS = 64
`ifdef LCD_SEQ_OP_TIMEOUT_EN
  , parameter int OP_TIMEOUT = 16
`endif
) (
  input  logic           clk,
  input  logic           reset,
  lcd_ctrl_seq_if.master bus
);

  typedef enum logic [2:0] {LOAD_RD, LOAD_TAIL, IDLE, OP, WRITE, FIN} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);

  state_t            state_q;
  logic              busy_q, done_q, irom_en_q, irb_rw_q, img_we_q, op_go_q, wb_en_q;
  logic [ADDR_W-1:0] addr_q, img_addr_q, addr_d;
  logic [2:0]        op_cmd_q;

`ifdef LCD_SEQ_OP_TIMEOUT_EN
  localparam int TMR_W = $clog2(OP_TIMEOUT + 1);
  logic [TMR_W-1:0] tmr_q;
  logic             err_q;
`endif

  assign addr_d = addr_q + ADDR_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= LOAD_RD;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      irom_en_q  <= 1'b1;
      irb_rw_q   <= 1'b1;
      addr_q     <= '0;
      img_we_q   <= 1'b0;
      img_addr_q <= '0;
      op_go_q    <= 1'b0;
      op_cmd_q   <= '0;
      wb_en_q    <= 1'b0;
`ifdef LCD_SEQ_OP_TIMEOUT_EN
      tmr_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      done_q   <= 1'b0;
      op_go_q  <= 1'b0;
      img_we_q <= 1'b0;
`ifdef LCD_SEQ_OP_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
      case (state_q)
        LOAD_RD: begin
          // IROM_EN still high means this is the setup edge right after reset
          if (irom_en_q) begin
            irom_en_q <= 1'b0;
            addr_q    <= '0;
          end else begin
            img_we_q   <= 1'b1;
            img_addr_q <= addr_q;
            if (addr_q == LAST_ADDR) begin
              state_q   <= LOAD_TAIL;
              irom_en_q <= 1'b1;
              addr_q    <= '0;
            end else begin
              addr_q <= addr_d;
            end
          end
        end
        LOAD_TAIL: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          img_addr_q <= '0;
        end
        IDLE: begin
          if (bus.cmd_valid && !busy_q) begin
            busy_q <= 1'b1;
            if (bus.cmd == 3'd0) begin
              state_q  <= WRITE;
              irb_rw_q <= 1'b0;
              wb_en_q  <= 1'b1;
              addr_q   <= '0;
            end else begin
              state_q  <= OP;
              op_cmd_q <= bus.cmd;
              op_go_q  <= 1'b1;
`ifdef LCD_SEQ_OP_TIMEOUT_EN
              tmr_q    <= TMR_W'(OP_TIMEOUT - 1);
`endif
            end
          end
        end
        OP: begin
          if (bus.op_ack) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
`ifdef LCD_SEQ_OP_TIMEOUT_EN
          else if (tmr_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
`endif
        end
        WRITE: begin
          if (addr_q == LAST_ADDR) begin
            state_q  <= FIN;
            irb_rw_q <= 1'b1;
            wb_en_q  <= 1'b0;
            done_q   <= 1'b1;
            addr_q   <= '0;
          end else begin
            addr_q <= addr_d;
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= LOAD_RD;
          busy_q    <= 1'b1;
          irom_en_q <= 1'b1;
          irb_rw_q  <= 1'b1;
          wb_en_q   <= 1'b0;
          addr_q    <= '0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.IROM_EN  = irom_en_q;
  assign bus.IRB_RW   = irb_rw_q;
  assign bus.ADDR     = addr_q;
  assign bus.img_we   = img_we_q;
  assign bus.img_addr = img_addr_q;
  assign bus.op_go    = op_go_q;
  assign bus.op_cmd   = op_cmd_q;
  assign bus.wb_en    = wb_en_q;
  assign bus.wb_addr  = addr_q;
`ifdef LCD_SEQ_OP_TIMEOUT_EN
  assign bus.err      = err_q;
`else
  assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_ctrl_seq.sv
// Directed bench for lcd_ctrl_seq: load, reset abort, writeback, ops, timeout.
module tb_lcd_ctrl_seq;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;
  int   nwe;
  int   ngo;

  lcd_ctrl_seq_if #(.ADDR_W(6)) bus ();

  lcd_ctrl_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b0;
    bus.cmd = 3'd0;
    bus.cmd_valid = 1'b0;
    bus.op_ack = 1'b0;

    // reset values
    repeat (3) tick();
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_irom_en", 32'(bus.IROM_EN), 32'd1);
    chk("rst_irb_rw", 32'(bus.IRB_RW), 32'd1);
    chk("rst_addr", 32'(bus.ADDR), 32'd0);
    chk("rst_img_we", 32'(bus.img_we), 32'd0);
    chk("rst_op_go", 32'(bus.op_go), 32'd0);
    chk("rst_wb_en", 32'(bus.wb_en), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);

    // partial load, then reset pulse at ADDR=20
    reset = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      tick();
      chk("load1_addr", 32'(bus.ADDR), 32'(k - 1));
      chk("load1_irom_en", 32'(bus.IROM_EN), 32'd0);
    end
    #2 reset = 1'b0;
    #1;
    chk("abort_irom_en", 32'(bus.IROM_EN), 32'd1);
    chk("abort_addr", 32'(bus.ADDR), 32'd0);
    chk("abort_img_we", 32'(bus.img_we), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd1);
    chk("abort_done", 32'(bus.done), 32'd0);
    tick();
    reset = 1'b1;

    // full load with cmd=5 held valid, which must be ignored
    bus.cmd = 3'd5;
    bus.cmd_valid = 1'b1;
    nwe = 0;
    ngo = 0;
    for (int k = 1; k <= 65; k++) begin
      tick();
      if (bus.img_we === 1'b1) nwe++;
      if (bus.op_go === 1'b1) ngo++;
      if (k <= 64) chk("load_addr", 32'(bus.ADDR), 32'(k - 1));
      chk("load_irom_en", 32'(bus.IROM_EN), (k <= 64) ? 32'd0 : 32'd1);
      chk("load_img_we", 32'(bus.img_we), (k >= 2) ? 32'd1 : 32'd0);
      if (k >= 2) chk("load_img_addr", 32'(bus.img_addr), 32'(k - 2));
      chk("load_irb_rw", 32'(bus.IRB_RW), 32'd1);
      chk("load_busy", 32'(bus.busy), 32'd1);
    end
    bus.cmd_valid = 1'b0;
    tick();
    chk("load_end_busy", 32'(bus.busy), 32'd0);
    chk("load_end_img_we", 32'(bus.img_we), 32'd0);
    chk("load_end_irom_en", 32'(bus.IROM_EN), 32'd1);
    chk("load_we_count", 32'(nwe), 32'd64);
    chk("load_go_count", 32'(ngo), 32'd0);

    // writeback, with cmd=5 valid during it
    bus.cmd = 3'd0;
    bus.cmd_valid = 1'b1;
    ngo = 0;
    for (int k = 0; k <= 63; k++) begin
      tick();
      if (bus.op_go === 1'b1) ngo++;
      chk("wr_addr", 32'(bus.ADDR), 32'(k));
      chk("wr_wb_addr", 32'(bus.wb_addr), 32'(k));
      chk("wr_irb_rw", 32'(bus.IRB_RW), 32'd0);
      chk("wr_wb_en", 32'(bus.wb_en), 32'd1);
      chk("wr_irom_en", 32'(bus.IROM_EN), 32'd1);
      chk("wr_busy", 32'(bus.busy), 32'd1);
      chk("wr_done", 32'(bus.done), 32'd0);
      if (k == 0) bus.cmd = 3'd5;
      if (k == 63) bus.cmd_valid = 1'b0;
    end
    tick();
    chk("fin_done", 32'(bus.done), 32'd1);
    chk("fin_irb_rw", 32'(bus.IRB_RW), 32'd1);
    chk("fin_wb_en", 32'(bus.wb_en), 32'd0);
    chk("fin_addr", 32'(bus.ADDR), 32'd0);
    chk("fin_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("post_done", 32'(bus.done), 32'd0);
    chk("post_busy", 32'(bus.busy), 32'd0);
    chk("wr_go_count", 32'(ngo), 32'd0);

    // op cmd=3, ack four cycles after op_go
    bus.cmd = 3'd3;
    bus.cmd_valid = 1'b1;
    tick();
    chk("op3_go", 32'(bus.op_go), 32'd1);
    chk("op3_cmd", 32'(bus.op_cmd), 32'd3);
    chk("op3_busy", 32'(bus.busy), 32'd1);
    bus.cmd_valid = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      tick();
      chk("op3_go_low", 32'(bus.op_go), 32'd0);
      chk("op3_busy_hold", 32'(bus.busy), 32'd1);
      chk("op3_cmd_hold", 32'(bus.op_cmd), 32'd3);
      chk("op3_irom_en", 32'(bus.IROM_EN), 32'd1);
      chk("op3_irb_rw", 32'(bus.IRB_RW), 32'd1);
      if (j == 4) bus.op_ack = 1'b1;
    end
    tick();
    bus.op_ack = 1'b0;
    chk("op3_busy_end", 32'(bus.busy), 32'd0);

    // op cmd=6 acked in the op_go cycle
    bus.cmd = 3'd6;
    bus.cmd_valid = 1'b1;
    tick();
    chk("op6_go", 32'(bus.op_go), 32'd1);
    bus.cmd_valid = 1'b0;
    bus.op_ack = 1'b1;
    tick();
    chk("op6_busy_end", 32'(bus.busy), 32'd0);
    chk("op6_cmd", 32'(bus.op_cmd), 32'd6);

    // stray op_ack in IDLE
    tick();
    chk("stray_ack_busy", 32'(bus.busy), 32'd0);
    chk("stray_ack_go", 32'(bus.op_go), 32'd0);
    bus.op_ack = 1'b0;

    // op cmd=2 with no ack
    bus.cmd = 3'd2;
    bus.cmd_valid = 1'b1;
    tick();
    chk("op2_go", 32'(bus.op_go), 32'd1);
    bus.cmd_valid = 1'b0;
    for (int j = 1; j <= 15; j++) begin
      tick();
      chk("op2_wait_busy", 32'(bus.busy), 32'd1);
      chk("op2_wait_err", 32'(bus.err), 32'd0);
    end
    tick();
`ifdef LCD_SEQ_OP_TIMEOUT_EN
    chk("to_err", 32'(bus.err), 32'd1);
    chk("to_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("to_err_clear", 32'(bus.err), 32'd0);
    chk("to_busy_after", 32'(bus.busy), 32'd0);
`else
    chk("noto_err", 32'(bus.err), 32'd0);
    chk("noto_busy", 32'(bus.busy), 32'd1);
    repeat (10) tick();
    chk("noto_busy_late", 32'(bus.busy), 32'd1);
    chk("noto_err_late", 32'(bus.err), 32'd0);
    bus.op_ack = 1'b1;
    tick();
    bus.op_ack = 1'b0;
    chk("noto_busy_ack", 32'(bus.busy), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
